sparse_feature_encoder: RTL and testbench

- Upstream stage of PE_UNIT. Consumes a dense, raster-ordered pixel stream for one input-channel image and drops zero pixels.
- Packs the surviving nonzeros into 4-lane beats of (value, col, row). These beats drive PE_UNIT's feature_value / feature_cols / feature_rows.
- Also produces the per-frame nonzero count, which feeds PE_UNIT's feature_valid_num, and a channel tag.

---
 rtl/sparse_feature_encoder.sv | 108 ++++++++++
 tb/tb_sparse_feature_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_feature_encoder.sv
// sparse_feature_encoder: drops zero pixels and packs nonzeros into 4-lane (value, col, row) beats
module sparse_feature_encoder #(
  parameter int col_length = 8,
  parameter int word_length = 8,
  parameter int double_word_length = 16,
  parameter int image_size = 28,
  parameter int num_channels = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [word_length-1:0]          pixel_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [4*word_length-1:0]        feature_value,
  output logic [4*col_length-1:0]         feature_cols,
  output logic [4*col_length-1:0]         feature_rows,
  output logic [3:0]                      lane_mask,
  output logic                            out_last,
  output logic [double_word_length-1:0]   out_channel,
  output logic [double_word_length-1:0]   feature_valid_num,
  output logic                            frame_done
);
  logic [col_length-1:0] row, col;
  logic [1:0] fill_idx;
  logic [4*word_length-1:0] buf_value, nxt_value;
  logic [4*col_length-1:0] buf_cols, buf_rows, nxt_cols, nxt_rows;
  logic [3:0] buf_mask, nxt_mask;
  logic [double_word_length-1:0] nz_count, nxt_count, channel;
  logic accept, nz, last_col, last_px, emit;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign nz = pixel_in != '0;
  assign last_col = col == col_length'(image_size - 1);
  assign last_px = last_col && row == col_length'(image_size - 1);
  assign emit = accept && ((nz && fill_idx == 2'd3) || (last_px && (fill_idx != 2'd0 || nz)));
  assign nxt_count = (accept && nz && nz_count != '1) ? nz_count + 1'b1 : nz_count;
  // pending beat with the incoming nonzero merged into lane fill_idx
  always_comb begin
    nxt_value = buf_value;
    nxt_cols = buf_cols;
    nxt_rows = buf_rows;
    nxt_mask = buf_mask;
    if (nz) begin
      nxt_value[int'(fill_idx)*word_length +: word_length] = pixel_in;
      nxt_cols[int'(fill_idx)*col_length +: col_length] = col;
      nxt_rows[int'(fill_idx)*col_length +: col_length] = row;
      nxt_mask[fill_idx] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
      fill_idx <= '0;
      buf_value <= '0;
      buf_cols <= '0;
      buf_rows <= '0;
      buf_mask <= '0;
      nz_count <= '0;
      channel <= '0;
      out_valid <= 1'b0;
      feature_value <= '0;
      feature_cols <= '0;
      feature_rows <= '0;
      lane_mask <= '0;
      out_last <= 1'b0;
      out_channel <= '0;
      feature_valid_num <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_px;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_px ? '0 : (last_col ? row + 1'b1 : row);
        if (emit) begin
          out_valid <= 1'b1;
          feature_value <= nxt_value;
          feature_cols <= nxt_cols;
          feature_rows <= nxt_rows;
          lane_mask <= nxt_mask;
          out_last <= last_px;
          out_channel <= channel;
          buf_value <= '0;
          buf_cols <= '0;
          buf_rows <= '0;
          buf_mask <= '0;
          fill_idx <= '0;
        end else if (nz) begin
          buf_value <= nxt_value;
          buf_cols <= nxt_cols;
          buf_rows <= nxt_rows;
          buf_mask <= nxt_mask;
          fill_idx <= fill_idx + 1'b1;
        end
        if (last_px) begin
          feature_valid_num <= nxt_count;
          nz_count <= '0;
          channel <= (channel == double_word_length'(num_channels - 1)) ? '0 : channel + 1'b1;
        end else begin
          nz_count <= nxt_count;
        end
      end
    end
  end
endmodule

// File: tb/tb_sparse_feature_encoder.sv
// tb_sparse_feature_encoder: random and directed 4x4 frames checked against a frame-level beat model
module tb_sparse_feature_encoder;
  localparam int N = 4;
  typedef struct packed {
    logic [31:0] value;
    logic [31:0] cols;
    logic [31:0] rows;
    logic [3:0]  mask;
    logic        last;
    logic [15:0] channel;
  } beat_t;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [7:0] pixel_in = 0;
  logic in_ready, out_valid, out_last, frame_done;
  logic [31:0] feature_value, feature_cols, feature_rows;
  logic [3:0] lane_mask;
  logic [15:0] out_channel, feature_valid_num;
  beat_t exp_q[$];
  logic [15:0] fvn_q[$];
  int ch = 0, n_chk = 0, n_pass = 0, frames_seen = 0, frames_exp = 0, cycles = 0;
  bit random_ready = 0, stalled = 0;
  beat_t held, cur, e;
  logic [7:0] f [N*N];

  sparse_feature_encoder #(.image_size(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready), .feature_value(feature_value),
    .feature_cols(feature_cols), .feature_rows(feature_rows), .lane_mask(lane_mask),
    .out_last(out_last), .out_channel(out_channel), .feature_valid_num(feature_valid_num),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycles++;
    if (cycles > 50000) begin
      $display("FAIL watchdog: cycles %0d limit 50000", cycles);
      $fatal(1, "timeout");
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // nonzeros fill lanes in raster order; a full group or the frame's last pixel closes a beat
  task automatic expect_frame(input logic [7:0] fr [N*N]);
    beat_t b;
    int n, cnt;
    b = '0; n = 0; cnt = 0;
    for (int p = 0; p < N*N; p++) begin
      if (fr[p] != 0) begin
        b.value[n*8 +: 8] = fr[p];
        b.cols[n*8 +: 8] = 8'(p % N);
        b.rows[n*8 +: 8] = 8'(p / N);
        b.mask[n] = 1'b1;
        n++;
        cnt++;
        if (n == 4) begin
          b.last = (p == N*N-1);
          b.channel = 16'(ch);
          exp_q.push_back(b);
          b = '0;
          n = 0;
        end
      end
    end
    if (n > 0) begin
      b.last = 1'b1;
      b.channel = 16'(ch);
      exp_q.push_back(b);
    end
    fvn_q.push_back(16'(cnt));
    frames_exp++;
    ch = (ch + 1) % 6;
  endtask

  task automatic drive(input logic [7:0] fr [N*N], input int cnt);
    int p = 0;
    while (p < cnt) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 4) != 0);
      pixel_in = fr[p];
      @(negedge clk);
      if (in_valid && in_ready) p++;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_frame(input logic [7:0] fr [N*N]);
    expect_frame(fr);
    drive(fr, N*N);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_lane_mask", lane_mask, 0);
    chk("rst_fvn", feature_valid_num, 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = random_ready ? ($urandom_range(0, 9) < 6) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) stalled = 0;
    else begin
      cur = '{feature_value, feature_cols, feature_rows, lane_mask, out_last, out_channel};
      if (stalled && out_valid) begin
        chk("hold_value", cur.value, held.value);
        chk("hold_coords", {cur.cols, cur.rows}, {held.cols, held.rows});
        chk("hold_ctrl", {cur.mask, cur.last, cur.channel}, {held.mask, held.last, held.channel});
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat_mask", lane_mask, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_value", cur.value, e.value);
          chk("beat_cols", cur.cols, e.cols);
          chk("beat_rows", cur.rows, e.rows);
          chk("beat_mask", cur.mask, e.mask);
          chk("beat_last", cur.last, e.last);
          chk("beat_channel", cur.channel, e.channel);
        end
      end
      stalled = out_valid && !out_ready;
      held = cur;
      if (frame_done) begin
        frames_seen++;
        if (fvn_q.size() == 0) chk("extra_frame_done", 64'(frames_seen), 64'(frames_exp));
        else chk("feature_valid_num", feature_valid_num, fvn_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1;
    foreach (f[i]) f[i] = 0;
    f[1] = 8'd26; f[6] = 8'hE6; f[8] = 8'd32; f[15] = 8'd48;
    run_frame(f);
    foreach (f[i]) f[i] = 0;
    f[0] = 8'd3; f[3] = 8'h80; f[5] = 8'd127; f[9] = 8'hFF; f[15] = 8'd9;
    run_frame(f);
    foreach (f[i]) f[i] = 0;
    run_frame(f);
    random_ready = 1;
    for (int k = 0; k < 40; k++) begin
      int dens;
      dens = (k % 4 == 0) ? 0 : (k % 4 == 1) ? 15 : (k % 4 == 2) ? 50 : 100;
      if (k >= 8) dens = $urandom_range(0, 100);
      foreach (f[i]) f[i] = ($urandom_range(0, 99) < dens) ? 8'($urandom_range(1, 255)) : 8'd0;
      run_frame(f);
    end
    drain();
    foreach (f[i]) f[i] = 0;
    f[0] = 8'd5; f[3] = 8'd7;
    drive(f, 7);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1;
    ch = 0;
    foreach (f[i]) f[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    f[0] = 8'hFB;
    run_frame(f);
    drain();
    chk("beats_left", 64'(exp_q.size()), 0);
    chk("frames", 64'(frames_seen), 64'(frames_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
